// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO read-side UART 8N1 transmitter.
package fifo_uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_BIT_CNT_W  = $clog2(UART_DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

  // Serial line level driven while sitting in a given state (data bits excluded).
  function automatic logic idle_level(input uart_state_e s);
    return (s != ST_START);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the drain stage: empty flag, read data and read strobe.
interface fifo_uart_tx_if
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);

  logic              buf_emp;
  logic [DATA_W-1:0] buf_out;
  logic              re_en;

  // master = consumer popping the FIFO, slave = the FIFO itself
  modport master (
    output re_en,
    input  buf_emp,
    input  buf_out
  );

  modport slave (
    input  re_en,
    output buf_emp,
    output buf_out
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarts on clr, ticks on the last count.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serialises each one as a UART 8N1 frame on tx.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_uart_tx_if.master       rd,
  output logic                 tx,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(DATA_W - 1);

  uart_state_e               r_state;
  uart_state_e               w_state_next;
  logic [DATA_W-1:0]         r_shift;
  logic [DATA_W-1:0]         w_shift_next;
  logic [UART_BIT_CNT_W-1:0] r_bit_cnt;
  logic [UART_BIT_CNT_W-1:0] w_bit_cnt_next;
  logic [15:0]               r_frame_cnt;
  logic [15:0]               w_frame_cnt_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      r_re_en;
  logic                      w_re_en_next;
  logic                      r_busy;
  logic                      w_busy_next;
  logic                      w_tick;
  logic                      w_clr;
  logic                      w_can_pop;

  // Only looked at in IDLE and on the last STOP cycle, so a pop never hits an empty FIFO.
  assign w_can_pop = en && !rd.buf_emp;

  // The baud counter restarts on every state entry so each bit gets a full period.
  assign w_clr = (w_state_next != r_state);

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_next     = r_state;
    w_shift_next     = r_shift;
    w_bit_cnt_next   = r_bit_cnt;
    w_frame_cnt_next = r_frame_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_can_pop) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_shift_next   = rd.buf_out;
        w_bit_cnt_next = '0;
        w_state_next   = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = ST_STOP;
          end else begin
            w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_frame_cnt_next = r_frame_cnt + 1'b1;
          w_state_next     = w_can_pop ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_tx_next    = idle_level(w_state_next);
    w_re_en_next = (w_state_next == ST_REQ);
    w_busy_next  = (w_state_next != ST_IDLE);
    if (w_state_next == ST_DATA) begin
      w_tx_next = w_shift_next[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame_cnt <= '0;
      r_tx        <= 1'b1;
      r_re_en     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_tx        <= w_tx_next;
      r_re_en     <= w_re_en_next;
      r_busy      <= w_busy_next;
    end
  end

  assign rd.re_en  = r_re_en;
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Cycle-stepped bench: FIFO queue model plus a frame-timing reference computed from the 8N1 rules.
module tb_fifo_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;
  localparam int BUSY_CYC  = FRAME_CYC + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;

  fifo_uart_tx_if u_if ();

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rd        (u_if),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [7:0]  fifo_q[$];
  int          pulse_q[$];
  logic        drv_en  = 1'b0;
  logic        drv_rst = 1'b0;
  logic        prev_rst = 1'b0;

  // reference model state
  logic        have_frame = 1'b0;
  int          req_cyc    = -1;
  int          fs         = 0;
  int          busy_end   = 0;
  logic [7:0]  fbyte      = 8'h00;
  logic [15:0] exp_frames = 16'h0;
  int          pops_exp   = 0;
  int          pulses     = 0;

  function automatic logic exp_tx_at(input int t);
    int idx;
    if (!have_frame || t < fs || t >= fs + FRAME_CYC) return 1'b1;
    idx = (t - fs) / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fbyte[idx-1];
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("tx", {15'd0, tx}, {15'd0, exp_tx_at(cyc)});
    chk("re_en", {15'd0, u_if.re_en}, {15'd0, (have_frame && cyc == req_cyc)});
    chk("busy", {15'd0, busy}, {15'd0, (have_frame && cyc >= req_cyc && cyc < busy_end)});
    chk("frame_cnt", frame_cnt, exp_frames);
    if (u_if.re_en === 1'b1) begin
      pulses++;
      pulse_q.push_back(cyc);
      if (fifo_q.size() > 0) u_if.buf_out = fifo_q.pop_front();
    end
    rst_n        = drv_rst;
    en           = drv_en;
    u_if.buf_emp = (fifo_q.size() == 0);
    if (prev_rst && !drv_rst) begin
      #1;
      chk("async_rst_tx", {15'd0, tx}, 16'd1);
      chk("async_rst_re_en", {15'd0, u_if.re_en}, 16'd0);
      chk("async_rst_busy", {15'd0, busy}, 16'd0);
      chk("async_rst_frame_cnt", frame_cnt, 16'd0);
    end
    prev_rst = drv_rst;
    if (!drv_rst) begin
      have_frame = 1'b0;
      busy_end   = 0;
      exp_frames = 16'h0;
    end else begin
      if (have_frame && cyc + 1 == busy_end) exp_frames = exp_frames + 16'd1;
      if (cyc + 1 >= busy_end && drv_en && fifo_q.size() > 0) begin
        have_frame = 1'b1;
        req_cyc    = cyc + 1;
        fs         = cyc + 3;
        busy_end   = cyc + 1 + BUSY_CYC;
        fbyte      = fifo_q[0];
        pops_exp++;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    u_if.buf_emp = 1'b1;
    u_if.buf_out = 8'h00;

    // reset held, then released with nothing queued
    drv_rst = 1'b0;
    run(3);
    drv_rst = 1'b1;
    run(3);

    // single byte 8'h11
    fifo_q.push_back(8'h11);
    drv_en = 1'b1;
    run(50);
    chk("single_pulses", 16'(pulses), 16'd1);
    chk("single_frames", frame_cnt, 16'd1);

    // back-to-back 8'h55, 8'hAA
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'hAA);
    run(95);
    chk("b2b_pulses", 16'(pulses), 16'd3);
    chk("b2b_gap", 16'(pulse_q[2] - pulse_q[1]), 16'd42);
    chk("b2b_frames", frame_cnt, 16'd3);

    // empty FIFO with enable held
    run(100);
    chk("empty_pulses", 16'(pulses), 16'd3);

    // three bytes queued, enable dropped during the first frame's data bits
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
    run(16);
    drv_en = 1'b0;
    run(60);
    chk("en_drop_left", 16'(fifo_q.size()), 16'd2);
    chk("en_drop_frames", frame_cnt, 16'd4);
    fifo_q.delete();
    run(2);

    // reset pulsed during data bits with two bytes queued
    fifo_q.push_back(8'($urandom));
    fifo_q.push_back(8'($urandom));
    drv_en = 1'b1;
    run(20);
    drv_rst = 1'b0;
    run(2);
    drv_rst = 1'b1;
    run(60);
    chk("rst_mid_left", 16'(fifo_q.size()), 16'd0);
    chk("rst_mid_frames", frame_cnt, 16'd1);

    // randomized traffic: pushes, enable toggles and occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) fifo_q.push_back(8'($urandom));
      if ($urandom_range(0, 39) == 0) drv_en = ~drv_en;
      if ($urandom_range(0, 249) == 0) begin
        drv_rst = 1'b0;
        run(2);
        drv_rst = 1'b1;
      end
      step();
    end
    drv_en = 1'b1;
    run(BUSY_CYC * (fifo_q.size() + 1) + 4);
    chk("final_pulses", 16'(pulses), 16'(pops_exp));
    chk("final_drained", 16'(fifo_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
